// File: rtl/btn_press_fsm_if.sv
// Signal bundle between the button classifier and its neighbours.
// The master drives tick and btn; the slave (the FSM) drives the classified outputs.
interface btn_press_fsm_if #(
  parameter int unsigned CNT_WIDTH = 8
) ();

  logic                 tick_i;
  logic                 btn_i;
  logic                 press_o;
  logic                 release_o;
  logic                 short_press_o;
  logic                 long_press_o;
  logic                 held_o;
  logic [CNT_WIDTH-1:0] press_count_o;

  modport master (
    output tick_i,
    output btn_i,
    input  press_o,
    input  release_o,
    input  short_press_o,
    input  long_press_o,
    input  held_o,
    input  press_count_o
  );

  modport slave (
    input  tick_i,
    input  btn_i,
    output press_o,
    output release_o,
    output short_press_o,
    output long_press_o,
    output held_o,
    output press_count_o
  );

endinterface

// File: rtl/btn_press_fsm.sv
// Tick-based debouncer and short/long press classifier with a saturating press counter.
// Define BTN_PRESS_REPEAT_EN to add auto-repeat press strobes after a long press.
module btn_press_fsm #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned LONG_TICKS     = 100,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned REPEAT_TICKS   = 10
) (
  input logic                  clk,
  input logic                  rst,
  btn_press_fsm_if.slave       bus_io
);

  localparam int unsigned CntW = $clog2(LONG_TICKS + 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_TICKS - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_TICKS - 1);

  if (DEBOUNCE_TICKS < 1 || LONG_TICKS <= DEBOUNCE_TICKS || REPEAT_TICKS < 1) begin : g_param_err
    $error("btn_press_fsm: invalid parameter set");
  end

  typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRelease} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      sav_q, sav_d;
  logic                 long_q, long_d;

  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 short_q, short_d;
  logic                 longp_q, longp_d;
  logic                 held_q, held_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic                 ev_press, ev_release, ev_long, ev_rpt;

`ifdef BTN_PRESS_REPEAT_EN
  localparam int unsigned RptW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_TICKS - 1);
  logic [RptW-1:0]      rpt_q, rpt_d;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sav_q     <= '0;
      long_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      longp_q   <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= '0;
`ifdef BTN_PRESS_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sav_q     <= sav_d;
      long_q    <= long_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      longp_q   <= longp_d;
      held_q    <= held_d;
      count_q   <= count_d;
`ifdef BTN_PRESS_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  // Next state. A btn level change always wins over a coincident tick.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sav_d      = sav_q;
    long_d     = long_q;
    ev_press   = 1'b0;
    ev_release = 1'b0;
    ev_long    = 1'b0;
    ev_rpt     = 1'b0;
`ifdef BTN_PRESS_REPEAT_EN
    rpt_d      = rpt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.btn_i) begin
          state_d = StDebPress;
          cnt_d   = '0;
        end
      end
      StDebPress: begin
        if (!bus_io.btn_i) begin
          state_d = StIdle;
        end else if (bus_io.tick_i) begin
          if (cnt_q == DebLast) begin
            state_d  = StHeld;
            cnt_d    = '0;
            long_d   = 1'b0;
            ev_press = 1'b1;
`ifdef BTN_PRESS_REPEAT_EN
            rpt_d    = '0;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHeld: begin
        if (!bus_io.btn_i) begin
          state_d = StDebRelease;
          sav_d   = cnt_q;
          cnt_d   = '0;
`ifdef BTN_PRESS_REPEAT_EN
          rpt_d   = '0;
`endif
        end else if (bus_io.tick_i) begin
          if (!long_q) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LongLast) begin
              long_d  = 1'b1;
              ev_long = 1'b1;
            end
          end
`ifdef BTN_PRESS_REPEAT_EN
          else if (rpt_q == RptLast) begin
            rpt_d  = '0;
            ev_rpt = 1'b1;
          end else begin
            rpt_d = rpt_q + RptW'(1);
          end
`endif
        end
      end
      StDebRelease: begin
        // Bounce back restores the hold count so long-press timing is not restarted.
        if (bus_io.btn_i) begin
          state_d = StHeld;
          cnt_d   = sav_q;
        end else if (bus_io.tick_i) begin
          if (cnt_q == DebLast) begin
            state_d    = StIdle;
            cnt_d      = '0;
            ev_release = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered output next values.
  always_comb begin
    press_d   = ev_press | ev_rpt;
    release_d = ev_release;
    short_d   = ev_release & ~long_q;
    longp_d   = ev_long;
    held_d    = (state_d == StHeld) || (state_d == StDebRelease);
    count_d   = count_q;
    if (press_d && !(&count_q)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  assign bus_io.press_o       = press_q;
  assign bus_io.release_o     = release_q;
  assign bus_io.short_press_o = short_q;
  assign bus_io.long_press_o  = longp_q;
  assign bus_io.held_o        = held_q;
  assign bus_io.press_count_o = count_q;

endmodule

// File: tb/tb_btn_press_fsm.sv
// Randomised and directed bench for btn_press_fsm using a per-cycle expectation scoreboard.
module tb_btn_press_fsm;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Long = 10;
  localparam int unsigned Rpt  = 3;
  localparam int unsigned CntW = 8;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_press_fsm_if #(.CNT_WIDTH(CntW)) bus ();

  btn_press_fsm #(
    .DEBOUNCE_TICKS(Deb),
    .LONG_TICKS    (Long),
    .CNT_WIDTH     (CntW),
    .REPEAT_TICKS  (Rpt)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  typedef struct packed {
    int unsigned     stamp;
    logic            press;
    logic            rel;
    logic            shrt;
    logic            lng;
    logic            held;
    logic [CntW-1:0] count;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned tdiv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: debounced level plus counts of qualifying ticks.
  bit          m_deb, m_pend, m_long;
  int unsigned m_run, m_hold, m_rpt, m_count;

  function automatic exp_t model_step(bit r, bit t, bit b);
    exp_t e;
    e = '0;
    if (r) begin
      m_deb = 0; m_pend = 0; m_long = 0;
      m_run = 0; m_hold = 0; m_rpt = 0; m_count = 0;
    end else if (b != m_deb) begin
      if (!m_pend) begin
        m_pend = 1; m_run = 0; m_rpt = 0;
      end else if (t) begin
        m_run++;
        if (m_run == Deb) begin
          m_deb = b; m_pend = 0;
          if (b) begin
            e.press = 1; m_hold = 0; m_long = 0; m_rpt = 0;
            if (m_count < CntMax) m_count++;
          end else begin
            e.rel = 1; e.shrt = !m_long;
          end
        end
      end
    end else if (m_pend) begin
      m_pend = 0;  // level returned: the coincident tick is not a hold tick
    end else if (m_deb && t) begin
      if (!m_long) begin
        m_hold++;
        if (m_hold == Long) begin m_long = 1; e.lng = 1; end
      end else begin
`ifdef BTN_PRESS_REPEAT_EN
        m_rpt++;
        if (m_rpt == Rpt) begin
          m_rpt = 0; e.press = 1;
          if (m_count < CntMax) m_count++;
        end
`endif
      end
    end
    e.held  = m_deb;
    e.count = m_count[CntW-1:0];
    return e;
  endfunction

  task automatic step(input bit r, input bit b);
    exp_t e;
    rst        = r;
    bus.btn_i  = b;
    bus.tick_i = (tdiv == 4);
    tdiv       = (tdiv == 4) ? 0 : tdiv + 1;
    e          = model_step(r, bus.tick_i, b);
    e.stamp    = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(r, b);
  endtask

  // Monitor: compare every presented output set against the queued expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (mon_e.stamp != cyc ||
          bus.press_o !== mon_e.press || bus.release_o !== mon_e.rel ||
          bus.short_press_o !== mon_e.shrt || bus.long_press_o !== mon_e.lng ||
          bus.held_o !== mon_e.held || bus.press_count_o !== mon_e.count) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got p=%b r=%b s=%b l=%b h=%b cnt=%0d want(cyc=%0d) p=%b r=%b s=%b l=%b h=%b cnt=%0d",
                 cyc, bus.press_o, bus.release_o, bus.short_press_o, bus.long_press_o,
                 bus.held_o, bus.press_count_o, mon_e.stamp, mon_e.press, mon_e.rel,
                 mon_e.shrt, mon_e.lng, mon_e.held, mon_e.count);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.btn_i = 1'b0;
    bus.tick_i = 1'b0;
    drive(1, 0, 4);
    // Clean short press.
    drive(0, 1, 40);
    drive(0, 0, 40);
    // Bounces shorter than the debounce window.
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 10);
      drive(0, 0, 10);
    end
    drive(0, 0, 20);
    // Long hold then release.
    drive(0, 1, (Deb + 20) * 5);
    drive(0, 0, 40);
    // Hold, one-tick release glitch, keep holding past the long threshold.
    drive(0, 1, (Deb + 8) * 5);
    drive(0, 0, 5);
    drive(0, 1, 30);
    drive(0, 0, 40);
    // Reset in the middle of a hold, button still pressed.
    drive(0, 1, 40);
    drive(1, 1, 2);
    drive(0, 1, 40);
    drive(0, 0, 40);
    // Randomised level segments of mixed lengths.
    for (int k = 0; k < 60; k++) begin
      int unsigned sel, len;
      sel = $urandom_range(0, 2);
      len = (sel == 0) ? $urandom_range(1, 15) :
            (sel == 1) ? $urandom_range(16, 60) : $urandom_range(61, 90);
      drive(0, k[0], len);
    end
    drive(0, 0, 40);
    // Enough presses to saturate the counter.
    for (int k = 0; k < 300; k++) begin
      drive(0, 1, 25);
      drive(0, 0, 25);
    end
    drive(1, 0, 2);
    drive(0, 0, 5);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
